// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequence controller: opcodes, halt conditions,
// flag bit positions, FSM states and the program step record.
package alu_pkg;

   localparam int unsigned DEF_WIDTH = 6;
   localparam int unsigned DEF_OP_W  = 2;

   localparam logic [1:0] OP_XNOR_OR_AND = 2'd0;
   localparam logic [1:0] OP_ROR         = 2'd1;
   localparam logic [1:0] OP_ADD         = 2'd2;
   localparam logic [1:0] OP_SUB         = 2'd3;

   localparam logic [1:0] COND_NONE = 2'b00;
   localparam logic [1:0] COND_ZF   = 2'b01;
   localparam logic [1:0] COND_SF   = 2'b10;
   localparam logic [1:0] COND_CF   = 2'b11;

   localparam int unsigned FLAG_GT = 3;
   localparam int unsigned FLAG_SF = 2;
   localparam int unsigned FLAG_CF = 1;
   localparam int unsigned FLAG_ZF = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } state_t;

   // Step record at the default widths; the controller packs the same field order.
   typedef struct packed {
      logic [1:0]           cond;
      logic                 chain;
      logic [DEF_OP_W-1:0]  op;
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
   } step_t;

   // True when the step's halt condition holds on the captured {gt, SF, CF, ZF}.
   function automatic logic cond_met(input logic [1:0] cond, input logic [3:0] flags);
      logic hit;
      hit = 1'b0;
      case (cond)
         COND_ZF: hit = flags[FLAG_ZF];
         COND_SF: hit = flags[FLAG_SF];
         COND_CF: hit = flags[FLAG_CF];
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/alu_seq_controller_mem.sv
// Program memory: DEPTH step records, synchronous write and clear, asynchronous read.
module alu_prog_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned REC_W = 17
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [REC_W-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [REC_W-1:0]         rdata_c
);

   logic [REC_W-1:0] mem [DEPTH];

   // Clear all entries on reset, otherwise commit one write per strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_c = mem[raddr];

endmodule

// File: rtl/alu_seq_controller.sv
// Sequences up to DEPTH ALU micro-ops against an external ALU of fixed latency,
// capturing each result/flags, optionally chaining results and halting on a flag.
module alu_seq_controller #(
   parameter int unsigned WIDTH   = 6,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned OP_W    = 2,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   prog_len,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [WIDTH-1:0]         prog_a,
   input  logic [WIDTH-1:0]         prog_b,
   input  logic [OP_W-1:0]          prog_op,
   input  logic [1:0]               prog_cond,
   input  logic                     prog_chain,
   input  logic [WIDTH-1:0]         result,
   input  logic                     gt_zero_flag,
   input  logic                     SF,
   input  logic                     CF,
   input  logic                     ZF,
   output logic [WIDTH-1:0]         a,
   output logic [WIDTH-1:0]         b,
   output logic [OP_W-1:0]          op,
   output logic                     busy,
   output logic                     done,
   output logic                     halted,
   output logic [$clog2(DEPTH):0]   steps_run,
   output logic [WIDTH-1:0]         last_result,
   output logic [3:0]               last_flags
);

   import alu_pkg::*;

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned LEN_W = IDX_W + 1;
   localparam int unsigned REC_W = 2 + 1 + OP_W + 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

   state_t             state;
   state_t             state_n;
   logic [IDX_W-1:0]   idx;
   logic [LEN_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt;

   logic [REC_W-1:0]   wrec_c;
   logic [REC_W-1:0]   rec_c;
   logic [1:0]         rec_cond_c;
   logic               rec_chain_c;
   logic [OP_W-1:0]    rec_op_c;
   logic [WIDTH-1:0]   rec_a_c;
   logic [WIDTH-1:0]   rec_b_c;
   logic               mem_we_c;
   logic [LEN_W-1:0]   idx_ext_c;
   logic [LEN_W-1:0]   len_clamp_c;
   logic               last_step_c;
   logic               halt_c;
   logic               capture_c;

   // Writes are only accepted while idle so a running program cannot change.
   assign mem_we_c = prog_we && (state == ST_IDLE);
   assign wrec_c   = {prog_cond, prog_chain, prog_op, prog_a, prog_b};

   alu_prog_mem #(
      .DEPTH (DEPTH),
      .REC_W (REC_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we      (mem_we_c),
      .waddr   (prog_addr),
      .wdata   (wrec_c),
      .raddr   (idx),
      .rdata_c (rec_c)
   );

   assign {rec_cond_c, rec_chain_c, rec_op_c, rec_a_c, rec_b_c} = rec_c;

   assign idx_ext_c   = LEN_W'(idx);
   assign len_clamp_c = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
   assign last_step_c = (idx_ext_c == (len_q - LEN_W'(1)));
   assign halt_c      = cond_met(rec_cond_c, last_flags);
   assign capture_c   = (cnt == CNT_W'(1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = (prog_len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: state_n = ST_WAIT;
         ST_WAIT: begin
            if (capture_c) begin
               state_n = ST_EVAL;
            end
         end
         ST_EVAL: state_n = (halt_c || last_step_c) ? ST_DONE : ST_LOAD;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Operand issue, latency countdown, result capture and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         a           <= '0;
         b           <= '0;
         op          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         steps_run   <= '0;
         last_result <= '0;
         last_flags  <= '0;
         idx         <= '0;
         len_q       <= '0;
         cnt         <= '0;
      end else begin
         busy <= (state_n == ST_LOAD) || (state_n == ST_WAIT) || (state_n == ST_EVAL);
         done <= (state_n == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  halted    <= 1'b0;
                  steps_run <= '0;
                  idx       <= '0;
                  len_q     <= len_clamp_c;
               end
            end
            ST_LOAD: begin
               a   <= rec_a_c;
               b   <= rec_chain_c ? last_result : rec_b_c;
               op  <= rec_op_c;
               cnt <= CNT_W'(ALU_LAT);
            end
            ST_WAIT: begin
               if (capture_c) begin
                  last_result <= result;
                  last_flags  <= {gt_zero_flag, SF, CF, ZF};
                  steps_run   <= idx_ext_c + LEN_W'(1);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_EVAL: begin
               if (halt_c) begin
                  halted <= 1'b1;
               end else if (!last_step_c) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
